// File: rtl/edge_detector_array.sv
// Multi-channel edge detector: per-channel synchroniser, debounce filter,
// registered rise/fall/any pulses and a sticky event flag with clear.
module edge_detector_array #(
  parameter int unsigned width_p       = 4,
  parameter int unsigned sync_stages_p = 2,
  parameter int unsigned debounce_p    = 4,
  parameter int unsigned sticky_mode_p = 2
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic [width_p-1:0] d_i,
  input  logic [width_p-1:0] en_i,
  input  logic [width_p-1:0] clear_i,
  output logic [width_p-1:0] level_o,
  output logic [width_p-1:0] rise_o,
  output logic [width_p-1:0] fall_o,
  output logic [width_p-1:0] any_o,
  output logic [width_p-1:0] sticky_o
);

  localparam int unsigned cnt_w_lp = $clog2(debounce_p + 1);
  localparam logic [cnt_w_lp-1:0] cnt_max_lp = cnt_w_lp'(debounce_p - 1);

  logic [width_p-1:0]  sync_q [sync_stages_p];
  logic [cnt_w_lp-1:0] cnt_q  [width_p];
  logic [width_p-1:0]  sync_s;
  logic [width_p-1:0]  level_q;
  logic [width_p-1:0]  level_d_q;
  logic [width_p-1:0]  rise_q;
  logic [width_p-1:0]  fall_q;
  logic [width_p-1:0]  sticky_q;
  logic [width_p-1:0]  rise_d;
  logic [width_p-1:0]  fall_d;
  logic [width_p-1:0]  sticky_set;

  assign sync_s = sync_q[sync_stages_p-1];

  // NOTE: the synchroniser and counter arrays are ordinary flops, not RAM, so
  // resetting every entry is cheap and required for a clean post-reset state.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int k = 0; k < int'(sync_stages_p); k++) sync_q[k] <= '0;
    end else begin
      // NOTE: non-blocking assignments make the chain shift one stage per
      // edge regardless of loop order; blocking would collapse it.
      sync_q[0] <= d_i;
      for (int k = 1; k < int'(sync_stages_p); k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // A level is accepted only after debounce_p consecutive disagreeing samples.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      level_q <= '0;
      for (int i = 0; i < int'(width_p); i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(width_p); i++) begin
        if (sync_s[i] == level_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == cnt_max_lp) begin
          level_q[i] <= sync_s[i];
          cnt_q[i]   <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + cnt_w_lp'(1);
        end
      end
    end
  end

  // level_d_q trails level_q by one cycle so each accepted change is seen once.
  assign rise_d = en_i &  level_q & ~level_d_q;
  assign fall_d = en_i & ~level_q &  level_d_q;

  // NOTE: defaulting the output first keeps this block free of inferred latches.
  always_comb begin
    sticky_set = rise_d | fall_d;
    case (sticky_mode_p)
      0:       sticky_set = rise_d;
      1:       sticky_set = fall_d;
      default: sticky_set = rise_d | fall_d;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      level_d_q <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      sticky_q  <= '0;
    end else begin
      level_d_q <= level_q;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      // A new event in the same cycle as a clear keeps the flag set.
      sticky_q  <= (sticky_q & ~clear_i) | sticky_set;
    end
  end

  assign level_o  = level_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign any_o    = rise_q | fall_q;
  assign sticky_o = sticky_q;

endmodule

// File: tb/tb_edge_detector_array.sv
// Scoreboard bench for edge_detector_array: two instances (sticky modes 2 and 1)
// checked every cycle against a sample-window reference model.
module tb_edge_detector_array;

  localparam int W = 4;
  localparam int S = 2;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] d = '0;
  logic [W-1:0] en = '0;
  logic [W-1:0] clr = '0;

  logic [W-1:0] a_level, a_rise, a_fall, a_any, a_sticky;
  logic [W-1:0] b_level, b_rise, b_fall, b_any, b_sticky;

  edge_detector_array #(.width_p(W), .sync_stages_p(S), .debounce_p(D), .sticky_mode_p(2)) dut_a (
    .clk_i(clk), .reset_ni(reset_n), .d_i(d), .en_i(en), .clear_i(clr),
    .level_o(a_level), .rise_o(a_rise), .fall_o(a_fall), .any_o(a_any), .sticky_o(a_sticky));

  edge_detector_array #(.width_p(W), .sync_stages_p(S), .debounce_p(D), .sticky_mode_p(1)) dut_b (
    .clk_i(clk), .reset_ni(reset_n), .d_i(d), .en_i(en), .clear_i(clr),
    .level_o(b_level), .rise_o(b_rise), .fall_o(b_fall), .any_o(b_any), .sticky_o(b_sticky));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] level;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] sticky_a;
    logic [W-1:0] sticky_b;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   rise_cnt[W];
  int   fall_cnt[W];
  int   rise_cyc[W];
  int   lvl_cyc[W];
  logic [W-1:0] prev_level = '0;

  // Reference model: level flips once the last D synchronised samples all disagree.
  logic [W-1:0] dhist[$];
  logic [W-1:0] m_l, m_l1, m_l2, m_sa, m_sb;

  function automatic void model_reset();
    m_l = '0; m_l1 = '0; m_l2 = '0; m_sa = '0; m_sb = '0;
    dhist.delete();
    for (int j = 0; j < S + D; j++) dhist.push_back('0);
  endfunction

  task automatic model_edge();
    exp_t e;
    logic [W-1:0] r, f;
    bit all_ne;
    m_l2 = m_l1;
    m_l1 = m_l;
    dhist.push_front(d);
    for (int ch = 0; ch < W; ch++) begin
      all_ne = 1'b1;
      for (int j = S; j < S + D; j++) if (dhist[j][ch] == m_l[ch]) all_ne = 1'b0;
      if (all_ne) m_l[ch] = ~m_l[ch];
    end
    void'(dhist.pop_back());
    r = en & m_l1 & ~m_l2;
    f = en & ~m_l1 & m_l2;
    m_sa = (m_sa & ~clr) | r | f;
    m_sb = (m_sb & ~clr) | f;
    e.level = m_l; e.rise = r; e.fall = f; e.sticky_a = m_sa; e.sticky_b = m_sb;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge reset_n) model_reset();

  always @(posedge clk) begin
    if (reset_n) begin
      cyc++;
      model_edge();
    end
  end

  // Monitor: one expected record per clock edge taken out of reset.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("dut_a outputs", {12'h0, a_level, a_rise, a_fall, a_any, a_sticky},
            {12'h0, e.level, e.rise, e.fall, e.rise | e.fall, e.sticky_a});
      check("dut_b outputs", {12'h0, b_level, b_rise, b_fall, b_any, b_sticky},
            {12'h0, e.level, e.rise, e.fall, e.rise | e.fall, e.sticky_b});
      for (int ch = 0; ch < W; ch++) begin
        if (a_rise[ch]) begin rise_cnt[ch]++; rise_cyc[ch] = cyc; end
        if (a_fall[ch]) fall_cnt[ch]++;
        if (a_level[ch] && !prev_level[ch]) lvl_cyc[ch] = cyc;
      end
      prev_level = a_level;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int k0;
    int rc[W];
    int fc[W];
    model_reset();
    for (int ch = 0; ch < W; ch++) begin
      rise_cnt[ch] = 0; fall_cnt[ch] = 0; rise_cyc[ch] = -1; lvl_cyc[ch] = -1;
    end
    en = '1;
    cycles(3);
    check("reset level", {28'h0, a_level}, 32'h0);
    check("reset sticky", {28'h0, a_sticky}, 32'h0);
    reset_n = 1'b1;

    // ch0 clean rise: level after k0+5, pulse after k0+6
    cycles(2);
    d[0] = 1'b1;
    k0 = cyc + 1;
    cycles(10);
    check("ch0 level latency", lvl_cyc[0] - k0, 5);
    check("ch0 rise latency", rise_cyc[0] - k0, 6);
    check("ch0 rise count", rise_cnt[0], 1);
    check("ch0 fall count", fall_cnt[0], 0);
    check("ch0 sticky", {31'h0, a_sticky[0]}, 32'h1);

    // ch1 short glitches are filtered, a 6-cycle pulse passes
    for (int len = 1; len <= 3; len++) begin
      d[1] = 1'b1; cycles(len);
      d[1] = 1'b0; cycles(10);
    end
    check("ch1 glitch rises", rise_cnt[1], 0);
    check("ch1 glitch falls", fall_cnt[1], 0);
    d[1] = 1'b1; cycles(6);
    d[1] = 1'b0; cycles(15);
    check("ch1 long rises", rise_cnt[1], 1);
    check("ch1 long falls", fall_cnt[1], 1);

    // ch2 bounce for 20 cycles then settle high
    for (int t = 0; t < 20; t++) begin
      d[2] = ~d[2]; cycles(1);
    end
    d[2] = 1'b1;
    k0 = cyc + 1;
    cycles(12);
    check("ch2 bounce rises", rise_cnt[2], 1);
    check("ch2 settle latency", rise_cyc[2] - k0, 6);

    // all channels low, clear flags, then simultaneous rise with en=1011
    d = '0; cycles(15);
    clr = '1; cycles(1); clr = '0;
    for (int ch = 0; ch < W; ch++) begin rc[ch] = rise_cnt[ch]; fc[ch] = fall_cnt[ch]; end
    en = 4'b1011;
    d = 4'b1111;
    k0 = cyc + 1;
    cycles(10);
    check("masked rise ch0", rise_cnt[0] - rc[0], 1);
    check("masked rise ch1", rise_cnt[1] - rc[1], 1);
    check("masked rise ch2", rise_cnt[2] - rc[2], 0);
    check("masked rise ch3", rise_cnt[3] - rc[3], 1);
    check("simultaneous rise", rise_cyc[0] - k0 + rise_cyc[3] - k0, 12);
    check("masked level", {28'h0, a_level}, 32'hF);
    check("masked sticky", {28'h0, a_sticky}, 32'hB);

    // sticky mode 1 (dut_b): rise does not set, fall does; set beats clear
    en = '1;
    d = '0; cycles(15);
    clr = '1; cycles(1); clr = '0;
    d[0] = 1'b1; cycles(10);
    check("mode1 rise no sticky", {31'h0, b_sticky[0]}, 32'h0);
    d[0] = 1'b0;
    cycles(6);
    clr[0] = 1'b1;
    cycles(1);
    clr[0] = 1'b0;
    check("mode1 fall pulse", {31'h0, b_fall[0]}, 32'h1);
    check("mode1 set beats clear", {31'h0, b_sticky[0]}, 32'h1);
    cycles(2);
    clr[0] = 1'b1; cycles(1); clr[0] = 1'b0;
    check("mode1 idle clear", {31'h0, b_sticky[0]}, 32'h0);

    // async reset in the middle of the ch3 debounce count
    cycles(5);
    d[3] = 1'b1;
    cycles(3);
    #2;
    reset_n = 1'b0;
    #1;
    check("async reset dut_a", {12'h0, a_level, a_rise, a_fall, a_any, a_sticky}, 32'h0);
    check("async reset dut_b", {12'h0, b_level, b_rise, b_fall, b_any, b_sticky}, 32'h0);
    for (int ch = 0; ch < W; ch++) rc[ch] = rise_cnt[ch];
    cycles(3);
    reset_n = 1'b1;
    k0 = cyc + 1;
    cycles(10);
    check("post-reset rise count", rise_cnt[3] - rc[3], 1);
    check("post-reset rise latency", rise_cyc[3] - k0, 6);

    // randomized traffic: slow per-channel toggles, random enables and clears
    for (int t = 0; t < 500; t++) begin
      for (int ch = 0; ch < W; ch++) if ($urandom_range(5) == 0) d[ch] = ~d[ch];
      en  = W'($urandom);
      clr = ($urandom_range(7) == 0) ? W'($urandom) : '0;
      cycles(1);
    end
    clr = '0;
    cycles(3);
    check("scoreboard drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
